// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module      : alu_arbiter_if
// Description : Requester/response bundle between issuing units and the
//               shared-ALU arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
  parameter int n = 32
);
  logic         Req0;
  logic         Req1;
  logic [n-1:0] A0;
  logic [n-1:0] B0;
  logic [n-1:0] A1;
  logic [n-1:0] B1;
  logic [2:0]   Ctr0;
  logic [2:0]   Ctr1;
  logic         Gnt0;
  logic         Gnt1;
  logic         RespValid;
  logic         RespId;
  logic         RespReady;
  logic [n-1:0] Result;
  logic         Zero;
  logic         Overflow;

  // master = requesters plus response consumer, slave = arbiter
  modport master (
    output Req0, Req1, A0, B0, A1, B1, Ctr0, Ctr1, RespReady,
    input  Gnt0, Gnt1, RespValid, RespId, Result, Zero, Overflow
  );

  modport slave (
    input  Req0, Req1, A0, B0, A1, B1, Ctr0, Ctr1, RespReady,
    output Gnt0, Gnt1, RespValid, RespId, Result, Zero, Overflow
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter (with internal alu)
// Description : Two-requester round-robin arbiter sequencing one shared ALU,
//               with a registered valid/ready response.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu #(
  parameter int n = 32
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic [2:0]   i_ctr,
  output logic [n-1:0] o_result,
  output logic         o_zero,
  output logic         o_overflow
);
  logic [n-1:0] w_sum;
  logic [n-1:0] w_diff;
  logic         w_add_ovf;
  logic         w_sub_ovf;

  assign w_sum     = i_a + i_b;
  assign w_diff    = i_a - i_b;
  assign w_add_ovf = (i_a[n-1] == i_b[n-1]) && (w_sum[n-1] != i_a[n-1]);
  assign w_sub_ovf = (i_a[n-1] != i_b[n-1]) && (w_diff[n-1] != i_a[n-1]);

  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    case (i_ctr)
      3'b000: o_result = w_sum;
      3'b001: begin o_result = w_sum;  o_overflow = w_add_ovf; end
      3'b010: o_result = i_a | i_b;
      3'b011: o_result = i_a & i_b;
      3'b100: o_result = w_diff;
      3'b101: begin o_result = w_diff; o_overflow = w_sub_ovf; end
      3'b110: o_result = {{(n-1){1'b0}}, (i_a < i_b)};
      3'b111: o_result = {{(n-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
    endcase
  end

  assign o_zero = (o_result == '0);
endmodule

module alu_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_gnt0;
  logic         w_gnt1;
  logic [n-1:0] r_op_a;
  logic [n-1:0] r_op_b;
  logic [2:0]   r_op_ctr;
  logic         r_owner_id;
  logic         r_last_gnt;
  logic         r_resp_valid;
  logic         r_resp_id;
  logic [n-1:0] r_result;
  logic         r_zero;
  logic         r_overflow;
  logic [n-1:0] w_alu_result;
  logic         w_alu_zero;
  logic         w_alu_overflow;

  alu #(.n(n)) u_alu (
    .i_a        (r_op_a),
    .i_b        (r_op_b),
    .i_ctr      (r_op_ctr),
    .o_result   (w_alu_result),
    .o_zero     (w_alu_zero),
    .o_overflow (w_alu_overflow)
  );

  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time goes first
        if (!rst) begin
          if (bus.Req0 && bus.Req1) begin
            w_gnt0 = r_last_gnt;
            w_gnt1 = !r_last_gnt;
          end else begin
            w_gnt0 = bus.Req0;
            w_gnt1 = bus.Req1;
          end
        end
        if (w_gnt0 || w_gnt1) w_next = S_EXEC;
      end
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (bus.RespReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_ctr     <= 3'b000;
      r_owner_id   <= 1'b0;
      r_last_gnt   <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_op_a     <= w_gnt1 ? bus.A1   : bus.A0;
        r_op_b     <= w_gnt1 ? bus.B1   : bus.B0;
        r_op_ctr   <= w_gnt1 ? bus.Ctr1 : bus.Ctr0;
        r_owner_id <= w_gnt1;
        r_last_gnt <= w_gnt1;
      end
      if (r_state == S_EXEC) begin
        r_result     <= w_alu_result;
        r_zero       <= w_alu_zero;
        r_overflow   <= w_alu_overflow;
        r_resp_id    <= r_owner_id;
        r_resp_valid <= 1'b1;
      end
      // Result flags stay put after the handshake; only the valid drops
      if (r_state == S_RESP && bus.RespReady) r_resp_valid <= 1'b0;
    end
  end

  assign bus.Gnt0      = w_gnt0;
  assign bus.Gnt1      = w_gnt1;
  assign bus.RespValid = r_resp_valid;
  assign bus.RespId    = r_resp_id;
  assign bus.Result    = r_result;
  assign bus.Zero      = r_zero;
  assign bus.Overflow  = r_overflow;
endmodule

`default_nettype wire
